// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha256_pkg
// Description : Shared SHA-256 types, round constants and schedule sigmas.
// Revision    : 1.0 - initial release
// ============================================================================
package sha256_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam word_t c_K_TABLE [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t k_const(input logic [5:0] idx);
        return c_K_TABLE[idx];
    endfunction

    function automatic word_t sigma0(input word_t x);
        return ((x >> 7)  | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
    endfunction

    function automatic word_t sigma1(input word_t x);
        return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha_w_expand.sv
`default_nettype none
// ============================================================================
// Module      : sha_w_expand
// Description : Combinational next-word generator for the 16-word window.
// Revision    : 1.0 - initial release
// ============================================================================
module sha_w_expand
    import sha256_pkg::*;
(
    input  logic [31:0] win0,
    input  logic [31:0] win1,
    input  logic [31:0] win9,
    input  logic [31:0] win14,
    output logic [31:0] next_word
);

    // Sum wraps naturally at 32 bits.
    assign next_word = sigma1(win14) + win9 + sigma0(win1) + win0;

endmodule
`default_nettype wire

// File: rtl/sha_msg_schedule.sv
`default_nettype none
// ============================================================================
// Module      : sha_msg_schedule
// Description : Streams W[0..63]/K[0..63] from one 512-bit block using a
//               16-word sliding window.
// Revision    : 1.0 - initial release
// ============================================================================
module sha_msg_schedule
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         block_valid,
    output logic         block_ready,
    input  logic [511:0] block_data,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_out,
    output logic [31:0]  k_out,
    output logic [5:0]   round_idx,
    output logic         last_round
);

    localparam logic [5:0] c_LAST_T = 6'd63;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [5:0]  r_t;
    word_t       r_win [0:15];
    word_t       w_blk_word [0:15];
    word_t       w_next_word;
    logic        w_accept;
    logic        w_xfer;
    logic        w_is_last;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_blk_words
            assign w_blk_word[gi] = block_data[511 - 32*gi -: 32];
        end
    endgenerate

    sha_w_expand u_expand (
        .win0      (r_win[0]),
        .win1      (r_win[1]),
        .win9      (r_win[9]),
        .win14     (r_win[14]),
        .next_word (w_next_word)
    );

    assign w_is_last = (r_t == c_LAST_T);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_xfer      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_accept = block_valid;
                if (block_valid) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_xfer = w_ready;
                if (w_ready && w_is_last) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_t     <= '0;
            for (int i = 0; i < 16; i++) r_win[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_t <= '0;
                for (int i = 0; i < 16; i++) r_win[i] <= w_blk_word[i];
            end else if (w_xfer) begin
                if (w_is_last) begin
                    r_t <= '0;
                end else begin
                    r_t <= r_t + 6'd1;
                    for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
                    r_win[15] <= w_next_word;
                end
            end
        end
    end

    // Outputs decode only registered state; w_ready never reaches them.
    assign block_ready = (r_state == ST_IDLE);
    assign w_valid     = (r_state == ST_RUN);
    assign w_out       = r_win[0];
    assign k_out       = (r_state == ST_RUN) ? k_const(r_t) : '0;
    assign round_idx   = r_t;
    assign last_round  = (r_state == ST_RUN) && w_is_last;

endmodule
`default_nettype wire

// File: tb/tb_sha_msg_schedule.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha_msg_schedule
// Description : Directed + randomized self-checking bench for sha_msg_schedule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha_msg_schedule;

    logic         clk = 1'b0;
    logic         rst;
    logic         block_valid;
    logic         block_ready;
    logic [511:0] block_data;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_out;
    logic [31:0]  k_out;
    logic [5:0]   round_idx;
    logic         last_round;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] ref_w [64];
    logic [31:0] cap_w [64];
    logic [31:0] cap_k [64];

    logic [31:0] ref_k [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    sha_msg_schedule dut (
        .clk         (clk),
        .rst         (rst),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .block_data  (block_data),
        .w_valid     (w_valid),
        .w_ready     (w_ready),
        .w_out       (w_out),
        .k_out       (k_out),
        .round_idx   (round_idx),
        .last_round  (last_round)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    // Full 64-entry schedule computed directly from the recurrence.
    task automatic build_model(input logic [511:0] blk);
        logic [31:0] s0, s1;
        for (int t = 0; t < 16; t++) ref_w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(ref_w[t-15], 7) ^ rotr(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3);
            s1 = rotr(ref_w[t-2], 17) ^ rotr(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10);
            ref_w[t] = 32'((64'(s1) + 64'(ref_w[t-7]) + 64'(s0) + 64'(ref_w[t-16])) % 64'h1_0000_0000);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = $urandom();
        return b;
    endfunction

    task automatic send_block(input logic [511:0] blk);
        int n;
        block_valid = 1'b1;
        block_data  = blk;
        n = 0;
        while (block_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_ready", {31'd0, block_ready}, 32'd1);
        @(posedge clk); #1;
        block_valid = 1'b0;
        block_data  = rand_block();
    endtask

    // Follows the stream from t=0 until stop_t words have transferred.
    task automatic run_stream(input logic [511:0] blk, input int stall_pct, input int stop_t);
        int t, edges;
        build_model(blk);
        t = 0;
        edges = 0;
        while (t < stop_t && edges < 4000) begin
            check($sformatf("w_valid t=%0d", t), {31'd0, w_valid}, 32'd1);
            check($sformatf("block_ready_run t=%0d", t), {31'd0, block_ready}, 32'd0);
            check($sformatf("w_out t=%0d", t), w_out, ref_w[t]);
            check($sformatf("k_out t=%0d", t), k_out, ref_k[t]);
            check($sformatf("round_idx t=%0d", t), {26'd0, round_idx}, 32'(t));
            check($sformatf("last_round t=%0d", t), {31'd0, last_round}, {31'd0, t == 63});
            cap_w[t] = w_out;
            cap_k[t] = k_out;
            w_ready = ($urandom_range(0, 99) >= stall_pct);
            @(posedge clk); #1;
            edges++;
            if (w_ready) t++;
        end
        w_ready = 1'b1;
        if (t < stop_t) check("stream_timeout", 32'(t), 32'(stop_t));
        if (stop_t == 64) begin
            check("done_w_valid", {31'd0, w_valid}, 32'd0);
            check("done_block_ready", {31'd0, block_ready}, 32'd1);
            if (stall_pct == 0) check("accept_to_ready_cycles", 32'(edges + 1), 32'd65);
        end
    endtask

    task automatic check_idle_reset_outputs(input string pfx);
        check({pfx, "_w_valid"},     {31'd0, w_valid},     32'd0);
        check({pfx, "_block_ready"}, {31'd0, block_ready}, 32'd1);
        check({pfx, "_w_out"},       w_out,                32'd0);
        check({pfx, "_k_out"},       k_out,                32'd0);
        check({pfx, "_round_idx"},   {26'd0, round_idx},   32'd0);
        check({pfx, "_last_round"},  {31'd0, last_round},  32'd0);
    endtask

    initial begin
        logic [511:0] abc, blk_a, blk_b, ones;
        abc = '0;
        abc[511:480] = 32'h61626380;
        abc[31:0]    = 32'h00000018;
        ones = '1;

        rst = 1'b1; block_valid = 1'b0; block_data = '0; w_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // "abc" block, no stalls.
        send_block(abc);
        run_stream(abc, 0, 64);
        check("abc_W0",  cap_w[0],  32'h61626380);
        check("abc_K0",  cap_k[0],  32'h428a2f98);
        check("abc_W16", cap_w[16], 32'h61626380);
        check("abc_W17", cap_w[17], 32'h000f0000);
        check("abc_K63", cap_k[63], 32'hc67178f2);

        // Random stalls on the same block and on random blocks.
        send_block(abc);
        run_stream(abc, 50, 64);
        for (int k = 0; k < 2; k++) begin
            blk_a = rand_block();
            send_block(blk_a);
            run_stream(blk_a, 50, 64);
        end

        // block_valid held high; data swapped during RUN.
        blk_a = rand_block();
        blk_b = rand_block();
        block_valid = 1'b1;
        block_data  = blk_a;
        @(posedge clk); #1;
        block_data  = blk_b;
        run_stream(blk_a, 0, 64);
        @(posedge clk); #1;
        block_valid = 1'b0;
        block_data  = rand_block();
        run_stream(blk_b, 30, 64);

        // Reset mid-block at t = 30, then restart.
        blk_a = rand_block();
        send_block(blk_a);
        run_stream(blk_a, 0, 30);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_reset_outputs("midrst");
        blk_b = rand_block();
        send_block(blk_b);
        run_stream(blk_b, 20, 64);

        // All-ones block exercises modulo-2^32 wrap.
        send_block(ones);
        run_stream(ones, 0, 64);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sha_msg_schedule.md
# sha_msg_schedule

Message-schedule stage directly upstream of the `sha_mainloop` round function. It accepts one 512-bit pre-padded message block and streams the 64 schedule words W[0..63] together with the matching round constants K[0..63], one pair per accepted transfer. A 16-word sliding window expands W[16..63] on the fly, so no 64-word storage is needed. Padding, chaining-value addition and final digest formation live outside this block.

## Interface
Parameters: none. All constants come from the shared package.

Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `block_valid`  in  1  a 512-bit block is offered
- `block_ready`  out  1  block can be accepted; high only in IDLE
- `block_data`  in  512  message block, W[0] in [511:480], W[15] in [31:0], big-endian words
- `w_valid`  out  1  `w_out`/`k_out`/`round_idx` are valid
- `w_ready`  in  1  consumer takes the current word this cycle
- `w_out`  out  32  schedule word W[t]
- `k_out`  out  32  round constant K[t]
- `round_idx`  out  6  t, 0..63
- `last_round`  out  1  high together with `w_valid` when t == 63

## Operation
- States:
  - IDLE: `block_ready` = 1, `w_valid` = 0.
  - RUN: `block_ready` = 0, `w_valid` = 1.
- IDLE -> RUN on `block_valid && block_ready`.
  - Load win[i] = word i of `block_data`, i = 0..15.
  - t := 0.
- RUN, transfer (`w_valid && w_ready`):
  - If t == 63: go to IDLE.
  - Else: t := t+1, win[i] := win[i+1] for i = 0..14, and win[15] := σ1(win[14]) + win[9] + σ0(win[1]) + win[0].
- RUN, no transfer (`w_ready` = 0): window, t and all outputs hold unchanged (stall).
- Expansion functions:
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - All additions are modulo 2^32; carries out of bit 31 are discarded.
- Output mapping: `w_out` = win[0], `k_out` = K[t], `round_idx` = t, `last_round` = (t == 63) in RUN.
- Expansion runs for every advance, including t ≥ 48. The surplus words computed past W[63] are don't-care.
- `block_valid` while in RUN is ignored. `block_data` is sampled only on the accept edge.
- Reset (including mid-block):
  - State := IDLE, t := 0, window := 0.
  - `w_valid` = 0, `w_out` = 0, `k_out` = 0, `round_idx` = 0, `last_round` = 0, `block_ready` = 1 from the first cycle after `rst` is sampled high.
  - The partially streamed block is discarded.

## Timing
- Accept edge N: W[0] and K[0] appear with `w_valid` = 1 in cycle N+1, registered.
- With `w_ready` held high:
  - W[t] is presented in cycle N+1+t.
  - The last word transfers in cycle N+64.
  - `block_ready` is high in cycle N+65.
  - Minimum spacing between block accepts is 65 cycles.
- Outputs are stable while `w_valid && !w_ready`, with no combinational path from `w_ready` to `w_out`.
- `block_ready` is a state decode with no combinational dependence on `block_valid`.

## Structure
- Shared package `sha256_pkg` holds:
  - the K[0..63] constant array,
  - `sigma0`/`sigma1` functions,
  - the state enum for IDLE/RUN,
  - the `word_t` 32-bit typedef.
- Sub-module `sha_w_expand`: combinational, takes win[0], win[1], win[9], win[14] and returns the next word. It can be unit-tested separately.
- Top level holds the FSM, the 6-bit counter, the 16x32 window register and the K lookup.

## Test plan
- "abc" block (word0 = 0x61626380, words 1..14 = 0, word15 = 0x00000018) with `w_ready` = 1:
  - W[0] = 0x61626380 with K[0] = 0x428a2f98.
  - W[16] = 0x61626380, W[17] = 0x000F0000.
  - `last_round` only at t = 63, where K[63] = 0xc67178f2.
- Full stream of the above vs. a software model: all 64 W/K pairs match. `block_ready` returns high exactly 65 cycles after accept.
- Random `w_ready` stalls (about 50% duty): the sequence equals the unstalled run, and outputs stay constant during each stall.
- `block_valid` held high continuously with two different blocks: the second is accepted only in IDLE after the first completes, and `block_data` changes during RUN have no effect.
- `rst` asserted at t = 30: next cycle `w_valid` = 0, `round_idx` = 0, `block_ready` = 1. A new block then restarts at W[0].
- All-ones block: modulo-2^32 wrap checked against the model for W[16..63].
